// File: rtl/mini_src_control_unit.sv
// Hard-wired Moore control sequencer for the Mini SRC datapath: fetch T0-T2, per-opcode
// execute T3-T7, with instruction-boundary pause and a terminal halt state.
module mini_src_control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR_Data,
    input  logic        CON_out,
    input  logic        Stop,
    output logic        Run,
    output logic        PC_in,
    output logic        IR_in,
    output logic        Y_in,
    output logic        Z_in,
    output logic        HI_in,
    output logic        LO_in,
    output logic        MAR_in,
    output logic        MDR_in,
    output logic        OutPort_in,
    output logic        IncPC,
    output logic        Rin,
    output logic        PC_out,
    output logic        Zhigh_out,
    output logic        Zlow_out,
    output logic        HI_out,
    output logic        LO_out,
    output logic        MDR_out,
    output logic        InPort_out,
    output logic        C_out,
    output logic        Rout,
    output logic        BAout,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic [4:0]  alu_instruction_bits,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_T0     = 4'd1,
        S_T1     = 4'd2,
        S_T2     = 4'd3,
        S_T3     = 4'd4,
        S_T4     = 4'd5,
        S_T5     = 4'd6,
        S_T6     = 4'd7,
        S_T7     = 4'd8,
        S_PAUSE  = 4'd9,
        S_HALTED = 4'd10
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    state_t     state_reg;
    logic       rst_done_reg;
    logic [4:0] opcode;
    state_t     last_state;

    logic is_rtype, is_imm, is_ldi, is_ld, is_st, is_muldiv, is_negnot;
    logic is_br, is_jr, is_mfhi, is_mflo, is_in, is_out, is_halt;

    assign opcode = IR_Data[31:27];

    always_comb begin
        is_rtype  = (opcode >= OP_ADD) && (opcode <= OP_SHL);
        is_imm    = (opcode >= OP_ADDI) && (opcode <= OP_ORI);
        is_ldi    = (opcode == OP_LDI);
        is_ld     = (opcode == OP_LD);
        is_st     = (opcode == OP_ST);
        is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
        is_negnot = (opcode == OP_NEG) || (opcode == OP_NOT);
        is_br     = (opcode == OP_BR);
        is_jr     = (opcode == OP_JR);
        is_mfhi   = (opcode == OP_MFHI);
        is_mflo   = (opcode == OP_MFLO);
        is_in     = (opcode == OP_IN);
        is_out    = (opcode == OP_OUT);
        is_halt   = (opcode == OP_HALT);
    end

    // Last execute step of the current instruction; nop and unknown opcodes end at T2.
    always_comb begin
        last_state = S_T2;
        if (is_rtype || is_imm || is_ldi || is_br)
            last_state = S_T5;
        else if (is_ld || is_st)
            last_state = S_T7;
        else if (is_muldiv)
            last_state = S_T6;
        else if (is_negnot)
            last_state = S_T4;
        else if (is_jr || is_mfhi || is_mflo || is_in || is_out)
            last_state = S_T3;
    end

    // rst_done_reg holds the sequencer in RESET for one full cycle after clr is released.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg    <= S_RESET;
            rst_done_reg <= 1'b0;
        end else begin
            rst_done_reg <= 1'b1;
            case (state_reg)
                S_RESET: begin
                    if (rst_done_reg)
                        state_reg <= S_T0;
                end
                S_PAUSE: begin
                    if (!Stop)
                        state_reg <= S_T0;
                end
                S_HALTED: state_reg <= S_HALTED;
                default: begin
                    if (state_reg == S_T2 && is_halt)
                        state_reg <= S_HALTED;
                    else if (state_reg == last_state)
                        state_reg <= Stop ? S_PAUSE : S_T0;
                    else
                        state_reg <= state_t'(state_reg + 4'd1);
                end
            endcase
        end
    end

    assign state_dbg = state_reg;
    assign Run = (state_reg >= S_T0) && (state_reg <= S_T7);

    always_comb begin
        PC_in = 1'b0; IR_in = 1'b0; Y_in = 1'b0; Z_in = 1'b0; HI_in = 1'b0; LO_in = 1'b0;
        MAR_in = 1'b0; MDR_in = 1'b0; OutPort_in = 1'b0; IncPC = 1'b0; Rin = 1'b0;
        PC_out = 1'b0; Zhigh_out = 1'b0; Zlow_out = 1'b0; HI_out = 1'b0; LO_out = 1'b0;
        MDR_out = 1'b0; InPort_out = 1'b0; C_out = 1'b0; Rout = 1'b0; BAout = 1'b0;
        Read = 1'b0; Write = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        alu_instruction_bits = 5'd0;
        case (state_reg)
            S_T0: begin
                PC_out = 1'b1; MAR_in = 1'b1; IncPC = 1'b1; Z_in = 1'b1;
            end
            S_T1: begin
                Zlow_out = 1'b1; PC_in = 1'b1; Read = 1'b1; MDR_in = 1'b1;
            end
            S_T2: begin
                MDR_out = 1'b1; IR_in = 1'b1;
            end
            S_T3: begin
                if (is_rtype || is_imm) begin
                    Grb = 1'b1; Rout = 1'b1; Y_in = 1'b1;
                end else if (is_ldi || is_ld || is_st) begin
                    Grb = 1'b1; BAout = 1'b1; Y_in = 1'b1;
                end else if (is_muldiv) begin
                    Gra = 1'b1; Rout = 1'b1; Y_in = 1'b1;
                end else if (is_negnot) begin
                    Grb = 1'b1; Rout = 1'b1; Z_in = 1'b1;
                    alu_instruction_bits = opcode;
                end else if (is_br) begin
                    PC_out = 1'b1; Y_in = 1'b1;
                end else if (is_jr) begin
                    Gra = 1'b1; Rout = 1'b1; PC_in = 1'b1;
                end else if (is_mfhi || is_mflo) begin
                    Gra = 1'b1; Rin = 1'b1;
                    HI_out = is_mfhi; LO_out = is_mflo;
                end else if (is_in) begin
                    Gra = 1'b1; Rin = 1'b1; InPort_out = 1'b1;
                end else if (is_out) begin
                    Gra = 1'b1; Rout = 1'b1; OutPort_in = 1'b1;
                end
            end
            S_T4: begin
                if (is_rtype) begin
                    Grc = 1'b1; Rout = 1'b1; Z_in = 1'b1;
                    alu_instruction_bits = opcode;
                end else if (is_imm) begin
                    C_out = 1'b1; Z_in = 1'b1;
                    alu_instruction_bits = (opcode == OP_ADDI) ? ALU_ADD :
                                           (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
                end else if (is_ldi || is_ld || is_st || is_br) begin
                    C_out = 1'b1; Z_in = 1'b1;
                    alu_instruction_bits = ALU_ADD;
                end else if (is_muldiv) begin
                    Grb = 1'b1; Rout = 1'b1; Z_in = 1'b1;
                    alu_instruction_bits = opcode;
                end else if (is_negnot) begin
                    Zlow_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            S_T5: begin
                if (is_rtype || is_imm || is_ldi) begin
                    Zlow_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_ld || is_st) begin
                    Zlow_out = 1'b1; MAR_in = 1'b1;
                end else if (is_muldiv) begin
                    Zlow_out = 1'b1; LO_in = 1'b1;
                end else if (is_br) begin
                    Zlow_out = 1'b1; PC_in = CON_out;
                end
            end
            S_T6: begin
                if (is_ld) begin
                    Read = 1'b1; MDR_in = 1'b1;
                end else if (is_st) begin
                    // Read stays low so MDR loads from the bus rather than memory.
                    Gra = 1'b1; Rout = 1'b1; MDR_in = 1'b1;
                end else if (is_muldiv) begin
                    Zhigh_out = 1'b1; HI_in = 1'b1;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_st) begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mini_src_control_unit.sv
// Table-driven bench for mini_src_control_unit: a continuous instruction stream checked
// cycle by cycle, plus hand sequences for mid-instruction reset, pause and halt.
module tb_mini_src_control_unit;

    logic        clk = 1'b0;
    logic        clr, CON_out, Stop;
    logic [31:0] IR_Data;
    logic Run, PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC, Rin;
    logic PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out, Rout, BAout;
    logic Read, Write, Gra, Grb, Grc;
    logic [4:0] alu_instruction_bits;
    logic [3:0] state_dbg;

    always #5 clk = ~clk;

    mini_src_control_unit dut (
        .clk(clk), .clr(clr), .IR_Data(IR_Data), .CON_out(CON_out), .Stop(Stop), .Run(Run),
        .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in), .HI_in(HI_in), .LO_in(LO_in),
        .MAR_in(MAR_in), .MDR_in(MDR_in), .OutPort_in(OutPort_in), .IncPC(IncPC), .Rin(Rin),
        .PC_out(PC_out), .Zhigh_out(Zhigh_out), .Zlow_out(Zlow_out), .HI_out(HI_out),
        .LO_out(LO_out), .MDR_out(MDR_out), .InPort_out(InPort_out), .C_out(C_out),
        .Rout(Rout), .BAout(BAout), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .alu_instruction_bits(alu_instruction_bits), .state_dbg(state_dbg)
    );

    logic [26:0] ctrl_act;
    assign ctrl_act = {Run, PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in,
                       IncPC, Rin, PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out,
                       InPort_out, C_out, Rout, BAout, Read, Write, Gra, Grb, Grc};

    localparam logic [26:0] RUN  = 27'h1 << 26, PCI  = 27'h1 << 25, IRI  = 27'h1 << 24;
    localparam logic [26:0] YI   = 27'h1 << 23, ZI   = 27'h1 << 22, HII  = 27'h1 << 21;
    localparam logic [26:0] LOI  = 27'h1 << 20, MARI = 27'h1 << 19, MDRI = 27'h1 << 18;
    localparam logic [26:0] OPI  = 27'h1 << 17, INC  = 27'h1 << 16, RIN  = 27'h1 << 15;
    localparam logic [26:0] PCO  = 27'h1 << 14, ZHO  = 27'h1 << 13, ZLO  = 27'h1 << 12;
    localparam logic [26:0] HIO  = 27'h1 << 11, LOO  = 27'h1 << 10, MDRO = 27'h1 << 9;
    localparam logic [26:0] INPO = 27'h1 << 8,  CO   = 27'h1 << 7,  ROUT = 27'h1 << 6;
    localparam logic [26:0] BAO  = 27'h1 << 5,  RD   = 27'h1 << 4,  WR   = 27'h1 << 3;
    localparam logic [26:0] GRA  = 27'h1 << 2,  GRB  = 27'h1 << 1,  GRC  = 27'h1 << 0;

    localparam logic [26:0] F0 = RUN | PCO | MARI | INC | ZI;
    localparam logic [26:0] F1 = RUN | ZLO | PCI | RD | MDRI;
    localparam logic [26:0] F2 = RUN | MDRO | IRI;

    localparam logic [3:0] SR = 4'd0, S0 = 4'd1, S1 = 4'd2, S2 = 4'd3, S3 = 4'd4, S4 = 4'd5;
    localparam logic [3:0] S5 = 4'd6, S6 = 4'd7, S7 = 4'd8, SP = 4'd9, SH = 4'd10;

    localparam logic [31:0] I_ADD  = 32'h18918000, I_MFHI = 32'hC2000000;
    localparam logic [31:0] I_BR   = 32'h98000000, I_ST   = 32'h10000000;
    localparam logic [31:0] I_LD   = 32'h00000000, I_MUL  = 32'h80000000;
    localparam logic [31:0] I_NEG  = 32'h88000000, I_NOP  = 32'hD0000000;
    localparam logic [31:0] I_ANDI = 32'h68000000, I_JR   = 32'hA0000000;
    localparam logic [31:0] I_IN   = 32'hB0000000, I_HALT = 32'hD8000000;

    typedef struct {
        logic [31:0] ir;
        logic        con;
        logic [26:0] ctrl;
        logic [4:0]  alu;
        logic [3:0]  st;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic void push(input logic [31:0] ir, input logic con, input logic [26:0] ctrl,
                                 input logic [4:0] alu, input logic [3:0] st);
        vec_t v;
        v.ir = ir; v.con = con; v.ctrl = ctrl; v.alu = alu; v.st = st;
        vecs.push_back(v);
    endfunction

    function automatic void fetch(input logic [31:0] ir, input logic con);
        push(ir, con, F0, 5'd0, S0);
        push(ir, con, F1, 5'd0, S1);
        push(ir, con, F2, 5'd0, S2);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string name, input logic [26:0] ctrl, input logic [4:0] alu,
                               input logic [3:0] st);
        check({name, "_ctrl"}, 32'(ctrl_act), 32'(ctrl));
        check({name, "_alu"}, 32'(alu_instruction_bits), 32'(alu));
        check({name, "_state"}, 32'(state_dbg), 32'(st));
    endtask

    initial begin
        // Two RESET cycles after release, then the instruction stream.
        push(I_ADD, 1'b0, 27'd0, 5'd0, SR);
        push(I_ADD, 1'b0, 27'd0, 5'd0, SR);
        fetch(I_ADD, 1'b1);
        push(I_ADD, 1'b1, RUN | GRB | ROUT | YI, 5'd0, S3);
        push(I_ADD, 1'b1, RUN | GRC | ROUT | ZI, 5'b00011, S4);
        push(I_ADD, 1'b1, RUN | ZLO | GRA | RIN, 5'd0, S5);
        fetch(I_MFHI, 1'b0);
        push(I_MFHI, 1'b0, RUN | GRA | RIN | HIO, 5'd0, S3);
        fetch(I_BR, 1'b1);
        push(I_BR, 1'b1, RUN | PCO | YI, 5'd0, S3);
        push(I_BR, 1'b1, RUN | CO | ZI, 5'b00011, S4);
        push(I_BR, 1'b1, RUN | ZLO | PCI, 5'd0, S5);
        fetch(I_BR, 1'b0);
        push(I_BR, 1'b0, RUN | PCO | YI, 5'd0, S3);
        push(I_BR, 1'b0, RUN | CO | ZI, 5'b00011, S4);
        push(I_BR, 1'b0, RUN | ZLO, 5'd0, S5);
        fetch(I_ST, 1'b0);
        push(I_ST, 1'b0, RUN | GRB | BAO | YI, 5'd0, S3);
        push(I_ST, 1'b0, RUN | CO | ZI, 5'b00011, S4);
        push(I_ST, 1'b0, RUN | ZLO | MARI, 5'd0, S5);
        push(I_ST, 1'b0, RUN | GRA | ROUT | MDRI, 5'd0, S6);
        push(I_ST, 1'b0, RUN | WR, 5'd0, S7);
        fetch(I_LD, 1'b0);
        push(I_LD, 1'b0, RUN | GRB | BAO | YI, 5'd0, S3);
        push(I_LD, 1'b0, RUN | CO | ZI, 5'b00011, S4);
        push(I_LD, 1'b0, RUN | ZLO | MARI, 5'd0, S5);
        push(I_LD, 1'b0, RUN | RD | MDRI, 5'd0, S6);
        push(I_LD, 1'b0, RUN | MDRO | GRA | RIN, 5'd0, S7);
        fetch(I_MUL, 1'b0);
        push(I_MUL, 1'b0, RUN | GRA | ROUT | YI, 5'd0, S3);
        push(I_MUL, 1'b0, RUN | GRB | ROUT | ZI, 5'b10000, S4);
        push(I_MUL, 1'b0, RUN | ZLO | LOI, 5'd0, S5);
        push(I_MUL, 1'b0, RUN | ZHO | HII, 5'd0, S6);
        fetch(I_NEG, 1'b0);
        push(I_NEG, 1'b0, RUN | GRB | ROUT | ZI, 5'b10001, S3);
        push(I_NEG, 1'b0, RUN | ZLO | GRA | RIN, 5'd0, S4);
        fetch(I_NOP, 1'b0);
        fetch(I_ANDI, 1'b0);
        push(I_ANDI, 1'b0, RUN | GRB | ROUT | YI, 5'd0, S3);
        push(I_ANDI, 1'b0, RUN | CO | ZI, 5'b00101, S4);
        push(I_ANDI, 1'b0, RUN | ZLO | GRA | RIN, 5'd0, S5);
        fetch(I_JR, 1'b0);
        push(I_JR, 1'b0, RUN | GRA | ROUT | PCI, 5'd0, S3);
        fetch(I_IN, 1'b0);
        push(I_IN, 1'b0, RUN | GRA | RIN | INPO, 5'd0, S3);

        clr = 1'b0; Stop = 1'b0; CON_out = 1'b0; IR_Data = I_ADD;
        repeat (2) @(posedge clk);
        #1;
        check_state("por", 27'd0, 5'd0, SR);
        clr = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            IR_Data = vecs[i].ir;
            CON_out = vecs[i].con;
            @(negedge clk);
            check_state($sformatf("v%0d", i), vecs[i].ctrl, vecs[i].alu, vecs[i].st);
            $display("vec %0d ir=%h con=%0d state=%0d ctrl=%h alu=%h", i, vecs[i].ir,
                     vecs[i].con, state_dbg, ctrl_act, alu_instruction_bits);
            step();
        end

        // Reset asserted during T4 of add clears everything immediately.
        IR_Data = I_ADD; CON_out = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check_state("pre_rst", RUN | GRC | ROUT | ZI, 5'b00011, S4);
        #2 clr = 1'b0;
        #1 check_state("mid_rst", 27'd0, 5'd0, SR);
        $display("txn mid-instruction reset state=%0d ctrl=%h", state_dbg, ctrl_act);
        step();
        clr = 1'b1;
        @(negedge clk);
        check_state("rel_a", 27'd0, 5'd0, SR);
        step();
        @(negedge clk);
        check_state("rel_b", 27'd0, 5'd0, SR);
        step();
        @(negedge clk);
        check_state("rel_t0", F0, 5'd0, S0);
        $display("txn reset release state=%0d ctrl=%h", state_dbg, ctrl_act);

        // Stop held from T1 only takes effect at the T5 boundary of add.
        step();
        Stop = 1'b1;
        repeat (4) step();
        @(negedge clk);
        check_state("stop_t5", RUN | ZLO | GRA | RIN, 5'd0, S5);
        step();
        @(negedge clk);
        check_state("pause_a", 27'd0, 5'd0, SP);
        step();
        Stop = 1'b0;
        @(negedge clk);
        check_state("pause_b", 27'd0, 5'd0, SP);
        step();
        @(negedge clk);
        check_state("resume", F0, 5'd0, S0);
        $display("txn pause/resume state=%0d ctrl=%h", state_dbg, ctrl_act);

        // halt: HALTED after T2 and stays there regardless of Stop.
        IR_Data = I_HALT;
        repeat (2) step();
        @(negedge clk);
        check_state("halt_t2", F2, 5'd0, S2);
        for (int k = 0; k < 22; k++) begin
            step();
            Stop = k[0];
            @(negedge clk);
            check_state($sformatf("halted%0d", k), 27'd0, 5'd0, SH);
        end
        $display("txn halt state=%0d run=%0d", state_dbg, Run);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
